// File: rtl/mfp_ahb_lite_sram_port.sv
// SRAM port behind the AHB-Lite decoder: one-entry posted-write buffer, byte-lane read forwarding.
// SRAM port is combinational; HRDATA follows one cycle after a read is issued; stalls one cycle on read/write/buffer conflict.
module mfp_ahb_lite_sram_port #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH+1:0] read_addr,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH+1:0] write_addr,
    input  logic [3:0]            write_mask,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    logic                  r_wb_valid;
    logic [ADDR_WIDTH-1:0] r_wb_addr;
    logic [3:0]            r_wb_mask;
    logic [31:0]           r_wb_data;
    logic [3:0]            r_fwd_mask;
    logic [31:0]           r_fwd_data;
    logic                  r_rd_pend;
    logic [31:0]           r_hrdata;

    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_rd_word;
    logic [ADDR_WIDTH-1:0] w_wr_word;
    logic                  w_ram_en;
    logic [3:0]            w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [31:0]           w_ram_wdata;
    logic                  w_ready;
    logic                  w_rd_issue;
    logic                  w_wb_valid_nx;
    logic [ADDR_WIDTH-1:0] w_wb_addr_nx;
    logic [3:0]            w_wb_mask_nx;
    logic [31:0]           w_wb_data_nx;
    logic                  w_fwd_hit;
    logic [31:0]           w_rdata_mux;
    logic                  w_unused;

    // A write with no byte lanes is an unsupported size and is simply dropped.
    assign w_wr      = write_enable & (|write_mask);
    assign w_rd_word = read_addr[ADDR_WIDTH+1:2];
    assign w_wr_word = write_addr[ADDR_WIDTH+1:2];
    assign w_unused  = ^{read_addr[1:0], write_addr[1:0]};

    always_comb begin
        w_ram_en      = 1'b0;
        w_ram_we      = 4'h0;
        w_ram_addr    = '0;
        w_ram_wdata   = 32'h0;
        w_ready       = 1'b1;
        w_rd_issue    = 1'b0;
        w_wb_valid_nx = r_wb_valid;
        w_wb_addr_nx  = r_wb_addr;
        w_wb_mask_nx  = r_wb_mask;
        w_wb_data_nx  = r_wb_data;
        if (!HRESET) begin
            if (read_enable && w_wr && r_wb_valid) begin
                // Port is busy retiring the old entry; the master re-presents the read next cycle.
                w_ram_en      = 1'b1;
                w_ram_we      = r_wb_mask;
                w_ram_addr    = r_wb_addr;
                w_ram_wdata   = r_wb_data;
                w_ready       = 1'b0;
                w_wb_addr_nx  = w_wr_word;
                w_wb_mask_nx  = write_mask;
                w_wb_data_nx  = HWDATA;
            end else if (read_enable) begin
                w_ram_en   = 1'b1;
                w_ram_addr = w_rd_word;
                w_rd_issue = 1'b1;
                if (w_wr) begin
                    w_wb_valid_nx = 1'b1;
                    w_wb_addr_nx  = w_wr_word;
                    w_wb_mask_nx  = write_mask;
                    w_wb_data_nx  = HWDATA;
                end
            end else if (w_wr && r_wb_valid) begin
                // Retire the older entry first so same-word writes land in order.
                w_ram_en      = 1'b1;
                w_ram_we      = r_wb_mask;
                w_ram_addr    = r_wb_addr;
                w_ram_wdata   = r_wb_data;
                w_wb_addr_nx  = w_wr_word;
                w_wb_mask_nx  = write_mask;
                w_wb_data_nx  = HWDATA;
            end else if (w_wr) begin
                w_ram_en    = 1'b1;
                w_ram_we    = write_mask;
                w_ram_addr  = w_wr_word;
                w_ram_wdata = HWDATA;
            end else if (r_wb_valid) begin
                w_ram_en      = 1'b1;
                w_ram_we      = r_wb_mask;
                w_ram_addr    = r_wb_addr;
                w_ram_wdata   = r_wb_data;
                w_wb_valid_nx = 1'b0;
            end
        end
    end

    assign w_fwd_hit = w_wb_valid_nx && (w_wb_addr_nx == w_rd_word);

    always_comb begin
        w_rdata_mux = ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (r_fwd_mask[i]) begin
                w_rdata_mux[8*i +: 8] = r_fwd_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_mask  <= 4'h0;
            r_wb_data  <= 32'h0;
            r_fwd_mask <= 4'h0;
            r_fwd_data <= 32'h0;
            r_rd_pend  <= 1'b0;
            r_hrdata   <= 32'h0;
        end else begin
            r_wb_valid <= w_wb_valid_nx;
            r_wb_addr  <= w_wb_addr_nx;
            r_wb_mask  <= w_wb_mask_nx;
            r_wb_data  <= w_wb_data_nx;
            r_rd_pend  <= w_rd_issue;
            if (w_rd_issue) begin
                r_fwd_mask <= w_fwd_hit ? w_wb_mask_nx : 4'h0;
                r_fwd_data <= w_wb_data_nx;
            end
            if (r_rd_pend) begin
                r_hrdata <= w_rdata_mux;
            end
        end
    end

    assign HRDATA    = r_rd_pend ? w_rdata_mux : r_hrdata;
    assign HREADYOUT = w_ready;
    assign ram_en    = w_ram_en;
    assign ram_we    = w_ram_we;
    assign ram_addr  = w_ram_addr;
    assign ram_wdata = w_ram_wdata;

endmodule

// File: tb/tb_mfp_ahb_lite_sram_port.sv
// Directed bench for mfp_ahb_lite_sram_port with a behavioural 1-cycle SRAM.
module tb_mfp_ahb_lite_sram_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0;
    logic [13:0] ra = '0;
    logic        we = 1'b0;
    logic [13:0] wa = '0;
    logic [3:0]  wm = '0;
    logic [31:0] wd = '0;
    logic [31:0] hrdata;
    logic        hready;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] mem [0:4095];

    integer total = 0;
    integer bad = 0;

    mfp_ahb_lite_sram_port #(.ADDR_WIDTH(12)) dut (
        .HCLK(clk), .HRESET(rst),
        .read_enable(re), .read_addr(ra),
        .write_enable(we), .write_addr(wa), .write_mask(wm), .HWDATA(wd),
        .HRDATA(hrdata), .HREADYOUT(hready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Read data is garbage unless a read was issued, so HRDATA hold is observable.
    always @(posedge clk) begin
        if (ram_en && ram_we == 4'h0) ram_rdata <= mem[ram_addr];
        else ram_rdata <= $urandom;
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr][8*i +: 8] = ram_wdata[8*i +: 8];
        end
    end

    task automatic drive(input logic i_re, input logic [13:0] i_ra, input logic i_we,
                         input logic [13:0] i_wa, input logic [3:0] i_wm, input logic [31:0] i_wd);
        @(negedge clk);
        re = i_re; ra = i_ra; we = i_we; wa = i_wa; wm = i_wm; wd = i_wd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 14'h0, 1'b0, 14'h0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        #1;
        total++; if (hready !== 1'b1) begin bad++; $display("FAIL rst_hready got=%b exp=1", hready); end
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en got=%b exp=0", ram_en); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", hrdata); end
        total++; if ({ram_we, ram_addr, ram_wdata} !== 48'h0) begin bad++; $display("FAIL rst_ram_port got=%h exp=0", {ram_we, ram_addr, ram_wdata}); end
        @(negedge clk); rst = 1'b0;
        idle();
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL idle_ram_en got=%b exp=0", ram_en); end
        // Fill the buffer (word 20), then reset before it drains.
        mem[20] = 32'h0;
        drive(1'b1, 14'h0, 1'b1, 14'h50, 4'hF, 32'h12345678);
        @(negedge clk);
        re = 1'b0; we = 1'b0; wm = 4'h0; rst = 1'b1;
        #1;
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL midrst_ram_en got=%b exp=0", ram_en); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL midrst_hrdata got=%h exp=0", hrdata); end
        @(negedge clk); rst = 1'b0;
        #1;
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL postrst_no_drain got=%b exp=0", ram_en); end
        idle();
        total++; if (mem[20] !== 32'h0) begin bad++; $display("FAIL postrst_mem20 got=%h exp=0", mem[20]); end
    endtask

    task automatic test_write_direct();
        drive(1'b0, 14'h0, 1'b1, 14'h10, 4'hF, 32'hDEADBEEF);
        total++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 4'hF, 12'd4, 32'hDEADBEEF})
            begin bad++; $display("FAIL direct_port got=%h exp=%h", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 4'hF, 12'd4, 32'hDEADBEEF}); end
        total++; if (hready !== 1'b1) begin bad++; $display("FAIL direct_hready got=%b exp=1", hready); end
        idle();
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL direct_no_buffer got=%b exp=0", ram_en); end
        total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL direct_mem got=%h exp=deadbeef", mem[4]); end
    endtask

    task automatic test_forward();
        mem[4] = 32'h11223344;
        drive(1'b1, 14'h10, 1'b1, 14'h11, 4'b0010, 32'hAABBCCDD);
        total++; if ({ram_en, ram_we, ram_addr, hready} !== {1'b1, 4'h0, 12'd4, 1'b1})
            begin bad++; $display("FAIL fwd_issue got=%h exp=%h", {ram_en, ram_we, ram_addr, hready}, {1'b1, 4'h0, 12'd4, 1'b1}); end
        idle();
        total++; if (hrdata !== 32'h1122CC44) begin bad++; $display("FAIL fwd_hrdata got=%h exp=1122cc44", hrdata); end
        total++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 4'b0010, 12'd4, 32'hAABBCCDD})
            begin bad++; $display("FAIL fwd_drain got=%h exp=%h", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 4'b0010, 12'd4, 32'hAABBCCDD}); end
        idle();
        total++; if (hrdata !== 32'h1122CC44) begin bad++; $display("FAIL fwd_hold got=%h exp=1122cc44", hrdata); end
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL fwd_empty got=%b exp=0", ram_en); end
        total++; if (mem[4] !== 32'h1122CC44) begin bad++; $display("FAIL fwd_mem got=%h exp=1122cc44", mem[4]); end
    endtask

    task automatic test_conflict();
        mem[8] = 32'h55667788;
        mem[9] = 32'h01020304;
        drive(1'b1, 14'h24, 1'b1, 14'h20, 4'hF, 32'hCAFEF00D);
        drive(1'b1, 14'h20, 1'b1, 14'h20, 4'b1000, 32'h99000000);
        total++; if (hready !== 1'b0) begin bad++; $display("FAIL cf_stall got=%b exp=0", hready); end
        total++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 4'hF, 12'd8, 32'hCAFEF00D})
            begin bad++; $display("FAIL cf_retire got=%h exp=%h", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 4'hF, 12'd8, 32'hCAFEF00D}); end
        total++; if (hrdata !== 32'h01020304) begin bad++; $display("FAIL cf_nofwd_hrdata got=%h exp=01020304", hrdata); end
        drive(1'b1, 14'h20, 1'b0, 14'h0, 4'h0, 32'h0);
        total++; if ({hready, ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, 4'h0, 12'd8})
            begin bad++; $display("FAIL cf_reissue got=%h exp=%h", {hready, ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 4'h0, 12'd8}); end
        idle();
        total++; if (hrdata !== 32'h99FEF00D) begin bad++; $display("FAIL cf_hrdata got=%h exp=99fef00d", hrdata); end
        total++; if ({ram_we, ram_wdata} !== {4'b1000, 32'h99000000})
            begin bad++; $display("FAIL cf_drain got=%h exp=%h", {ram_we, ram_wdata}, {4'b1000, 32'h99000000}); end
        idle();
        total++; if (mem[8] !== 32'h99FEF00D) begin bad++; $display("FAIL cf_mem got=%h exp=99fef00d", mem[8]); end
    endtask

    task automatic test_back_to_back();
        mem[12] = 32'h0;
        mem[13] = 32'h0D0D0D0D;
        drive(1'b1, 14'h34, 1'b1, 14'h30, 4'hF, 32'h1);
        total++; if ({hready, ram_we} !== {1'b1, 4'h0}) begin bad++; $display("FAIL b2b_first got=%h exp=10", {hready, ram_we}); end
        drive(1'b1, 14'h34, 1'b1, 14'h30, 4'hF, 32'h2);
        total++; if ({hready, ram_we, ram_addr, ram_wdata} !== {1'b0, 4'hF, 12'd12, 32'h1})
            begin bad++; $display("FAIL b2b_second got=%h exp=%h", {hready, ram_we, ram_addr, ram_wdata}, {1'b0, 4'hF, 12'd12, 32'h1}); end
        drive(1'b1, 14'h34, 1'b0, 14'h0, 4'h0, 32'h0);
        total++; if ({hready, ram_we, ram_addr} !== {1'b1, 4'h0, 12'd13})
            begin bad++; $display("FAIL b2b_reissue got=%h exp=%h", {hready, ram_we, ram_addr}, {1'b1, 4'h0, 12'd13}); end
        drive(1'b1, 14'h30, 1'b0, 14'h0, 4'h0, 32'h0);
        total++; if (hrdata !== 32'h0D0D0D0D) begin bad++; $display("FAIL b2b_rd13 got=%h exp=0d0d0d0d", hrdata); end
        idle();
        total++; if (hrdata !== 32'h2) begin bad++; $display("FAIL b2b_hrdata got=%h exp=2", hrdata); end
        total++; if ({ram_we, ram_addr, ram_wdata} !== {4'hF, 12'd12, 32'h2})
            begin bad++; $display("FAIL b2b_drain got=%h exp=%h", {ram_we, ram_addr, ram_wdata}, {4'hF, 12'd12, 32'h2}); end
        idle();
        total++; if (mem[12] !== 32'h2) begin bad++; $display("FAIL b2b_mem got=%h exp=2", mem[12]); end
    endtask

    task automatic test_mask_zero();
        drive(1'b0, 14'h0, 1'b1, 14'h40, 4'h0, 32'hFFFFFFFF);
        total++; if ({ram_en, hready} !== 2'b01) begin bad++; $display("FAIL m0_idle got=%b exp=01", {ram_en, hready}); end
        drive(1'b1, 14'h54, 1'b1, 14'h58, 4'hF, 32'h12345678);
        drive(1'b1, 14'h54, 1'b1, 14'h58, 4'h0, 32'hFFFFFFFF);
        total++; if ({hready, ram_en, ram_we} !== {1'b1, 1'b1, 4'h0})
            begin bad++; $display("FAIL m0_nostall got=%h exp=%h", {hready, ram_en, ram_we}, {1'b1, 1'b1, 4'h0}); end
        idle();
        total++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 4'hF, 12'd22, 32'h12345678})
            begin bad++; $display("FAIL m0_buffer_kept got=%h exp=%h", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 4'hF, 12'd22, 32'h12345678}); end
        idle();
        total++; if (mem[16] !== 32'h0) begin bad++; $display("FAIL m0_mem16 got=%h exp=0", mem[16]); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        test_reset();
        test_write_direct();
        test_forward();
        test_conflict();
        test_back_to_back();
        test_mask_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
